// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand/op input channel, result output channel
// and the multiplier busy indication.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] mul_high;
  logic [3:0]       SREG;
  logic             busy;

  // Producer/consumer side (register-file read stage and writeback)
  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, result, mul_high, SREG, busy
  );

  // ALU side
  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, result, mul_high, SREG, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops and a shift-add multiplier.
// Results, the high product half and {V,N,C,Z} flags are registered and held
// until the consumer takes them.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int            SW       = $clog2(WIDTH);
  localparam int            MSB      = WIDTH - 1;
  localparam logic [SW-1:0] LAST_CNT = SW'(WIDTH - 1);
  localparam logic [SW:0]   W_FULL   = (SW + 1)'(WIDTH);
  localparam logic          MUL_ON   = (MUL_EN != 0);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4,  OP_XOR = 4'd5,  OP_NOR = 4'd6,  OP_CMP = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_SAR = 4'd10, OP_ROL = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12, OP_INC = 4'd13, OP_DEC = 4'd14, OP_PSB = 4'd15;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand, r_acc_hi, r_acc_lo;
  logic [WIDTH-1:0] r_result, r_mul_high;
  logic [3:0]       r_sreg;
  logic             r_out_valid, r_busy;

  logic w_in_ready, w_accept, w_consume, w_is_mul;
  logic w_mul_start, w_single_load, w_mul_last;

  // Single-cycle datapath intermediates
  logic [WIDTH:0]   w_sum, w_diff, w_inc, w_dec, w_shl_wide, w_shr_wide;
  logic [WIDTH-1:0] w_sar, w_rol, w_ror;
  logic [SW-1:0]    w_amt;
  logic [SW:0]      w_rot_amt;
  logic [WIDTH-1:0] w_res, w_fsrc;
  logic             w_c, w_v;
  logic [3:0]       w_sreg;

  // Multiplier step intermediates
  logic [WIDTH:0]   w_step_sum;
  logic [WIDTH-1:0] w_step_hi, w_step_lo;
  logic [3:0]       w_mul_sreg;

  assign w_in_ready    = (r_state == S_IDLE) & (~r_out_valid | bus.out_ready);
  assign w_accept      = bus.in_valid & w_in_ready;
  assign w_consume     = r_out_valid & bus.out_ready;
  assign w_is_mul      = (bus.op == OP_MUL) & MUL_ON;
  assign w_mul_start   = w_accept & w_is_mul;
  assign w_single_load = w_accept & ~w_is_mul;
  assign w_mul_last    = (r_state == S_MUL) & (r_cnt == LAST_CNT);

  // Carry/borrow-extended arithmetic; bit WIDTH is the carry or borrow out
  assign w_sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff = {1'b0, bus.A} - {1'b0, bus.B};
  assign w_inc  = {1'b0, bus.A} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec  = {1'b0, bus.A} - {{WIDTH{1'b0}}, 1'b1};

  // Shifters: the extra bit of each wide form catches the last bit moved out
  assign w_amt      = bus.B[SW-1:0];
  assign w_rot_amt  = W_FULL - {1'b0, w_amt};
  assign w_shl_wide = {1'b0, bus.A} << w_amt;
  assign w_shr_wide = {bus.A, 1'b0} >> w_amt;
  assign w_sar      = $signed(bus.A) >>> w_amt;
  assign w_rol      = (bus.A << w_amt) | (bus.A >> w_rot_amt);
  assign w_ror      = (bus.A >> w_amt) | (bus.A << w_rot_amt);

  // One shift-add iteration: conditionally add the multiplicand, shift {carry,hi,lo} right
  assign w_step_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : {(WIDTH + 1){1'b0}});
  assign w_step_hi  = w_step_sum[WIDTH:1];
  assign w_step_lo  = {w_step_sum[0], r_acc_lo[WIDTH-1:1]};
  assign w_mul_sreg = {(|w_step_hi), w_step_hi[MSB], (|w_step_hi), ~(|{w_step_hi, w_step_lo})};

  // Single-cycle result and flag selection
  always_comb begin
    w_res  = {WIDTH{1'b0}};
    w_fsrc = {WIDTH{1'b0}};
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_sreg = 4'b0000;
    case (bus.op)
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (bus.A[MSB] == bus.B[MSB]) & (w_sum[MSB] != bus.A[MSB]);
      end
      OP_SUB, OP_CMP: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[WIDTH];
        w_v   = (bus.A[MSB] != bus.B[MSB]) & (w_diff[MSB] != bus.A[MSB]);
      end
      OP_MUL: begin
        w_res = {WIDTH{1'b0}};
        w_v   = 1'b1;
      end
      OP_AND: w_res = bus.A & bus.B;
      OP_OR:  w_res = bus.A | bus.B;
      OP_XOR: w_res = bus.A ^ bus.B;
      OP_NOR: w_res = ~(bus.A | bus.B);
      OP_SHL: begin
        w_res = w_shl_wide[MSB:0];
        w_c   = w_shl_wide[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr_wide[WIDTH:1];
        w_c   = w_shr_wide[0];
      end
      OP_SAR: begin
        w_res = w_sar;
        w_c   = w_shr_wide[0];
      end
      OP_ROL: begin
        w_res = w_rol;
        w_c   = w_shl_wide[WIDTH];
      end
      OP_ROR: begin
        w_res = w_ror;
        w_c   = w_shr_wide[0];
      end
      OP_INC: begin
        w_res = w_inc[MSB:0];
        w_c   = w_inc[WIDTH];
        w_v   = ~bus.A[MSB] & w_inc[MSB];
      end
      OP_DEC: begin
        w_res = w_dec[MSB:0];
        w_c   = w_dec[WIDTH];
        w_v   = bus.A[MSB] & ~w_dec[MSB];
      end
      OP_PSB:  w_res = bus.B;
      default: w_res = {WIDTH{1'b0}};
    endcase
    // CMP reports subtraction flags but passes A through as the result
    w_fsrc = w_res;
    w_res  = (bus.op == OP_CMP) ? bus.A : w_res;
    // The disabled multiplier reports overflow only
    w_sreg = (bus.op == OP_MUL) ? 4'b1000
                                : {w_v, w_fsrc[MSB], w_c, (w_fsrc == {WIDTH{1'b0}})};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: IDLE -> MUL on a multiply, MUL -> DONE after WIDTH steps, DONE -> IDLE on take
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_mul_start ? S_MUL : S_IDLE;
      S_MUL:   w_state_nxt = (r_cnt == LAST_CNT) ? S_DONE : S_MUL;
      S_DONE:  w_state_nxt = bus.out_ready ? S_IDLE : S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplier operand latch, accumulator iteration and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= {WIDTH{1'b0}};
      r_acc_hi <= {WIDTH{1'b0}};
      r_acc_lo <= {WIDTH{1'b0}};
      r_cnt    <= {SW{1'b0}};
      r_busy   <= 1'b0;
    end else if (w_mul_start) begin
      r_mcand  <= bus.A;
      r_acc_lo <= bus.B;
      r_acc_hi <= {WIDTH{1'b0}};
      r_cnt    <= {SW{1'b0}};
      r_busy   <= 1'b1;
    end else if (r_state == S_MUL) begin
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
      r_cnt    <= r_cnt + SW'(1);
      r_busy   <= ~w_mul_last;
    end
  end

  // Output registers: load on a single-cycle accept or the final multiply step, hold under back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= {WIDTH{1'b0}};
      r_mul_high  <= {WIDTH{1'b0}};
      r_sreg      <= 4'b0000;
      r_out_valid <= 1'b0;
    end else if (w_single_load) begin
      r_result    <= w_res;
      r_mul_high  <= {WIDTH{1'b0}};
      r_sreg      <= w_sreg;
      r_out_valid <= 1'b1;
    end else if (w_mul_last) begin
      r_result    <= w_step_lo;
      r_mul_high  <= w_step_hi;
      r_sreg      <= w_mul_sreg;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.mul_high  = r_mul_high;
  assign bus.SREG      = r_sreg;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8, MUL_EN=1): scoreboard of expected results
// produced by an integer reference model, plus scenario tasks with inline checks.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] sreg;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   n_pops   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model written with plain integer arithmetic and bit-by-bit shifting
  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    int r, hi, s, sa, sb, amt, p;
    logic c, v, n, z;
    r = 0; hi = 0; c = 1'b0; v = 1'b0;
    amt = b % 8;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0: begin s = a + b; r = s % 256; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      1, 7: begin s = a - b; r = (s + 256) % 256; c = (a < b); v = (sa - sb > 127) || (sa - sb < -128); end
      2: begin p = a * b; r = p % 256; hi = p / 256; c = (hi != 0); v = (hi != 0); end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (~(a | b)) & 255;
      8:  begin r = a; for (int k = 0; k < amt; k++) begin c = ((r >> 7) & 1) != 0; r = (r << 1) & 255; end end
      9:  begin r = a; for (int k = 0; k < amt; k++) begin c = (r & 1) != 0; r = r >> 1; end end
      10: begin r = a; for (int k = 0; k < amt; k++) begin c = (r & 1) != 0; r = (r >> 1) | (r & 128); end end
      11: begin r = a; for (int k = 0; k < amt; k++) begin c = ((r >> 7) & 1) != 0; r = ((r << 1) & 255) | (c ? 1 : 0); end end
      12: begin r = a; for (int k = 0; k < amt; k++) begin c = (r & 1) != 0; r = (r >> 1) | (c ? 128 : 0); end end
      13: begin s = a + 1; r = s % 256; c = (s > 255); v = (sa + 1 > 127); end
      14: begin s = a - 1; r = (s + 256) % 256; c = (a == 0); v = (sa - 1 < -128); end
      default: r = b;
    endcase
    if (op == 2) begin
      n = (hi >= 128);
      z = (r == 0) && (hi == 0);
    end else begin
      n = (r >= 128);
      z = (r == 0);
    end
    e.res  = (op == 7) ? 8'(a) : 8'(r);
    e.hi   = 8'(hi);
    e.sreg = {v, n, c, z};
    return e;
  endfunction

  // Scoreboard: every consumed result is compared against the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got result=%h mul_high=%h SREG=%b with nothing expected",
                 bus.result, bus.mul_high, bus.SREG);
      end else begin
        mon_e = sb_q.pop_front();
        n_pops++;
        if ({bus.result, bus.mul_high, bus.SREG} !== {mon_e.res, mon_e.hi, mon_e.sreg}) begin
          n_errors++;
          $display("FAIL sb_compare: got result=%h mul_high=%h SREG=%b, expected result=%h mul_high=%h SREG=%b",
                   bus.result, bus.mul_high, bus.SREG, mon_e.res, mon_e.hi, mon_e.sreg);
        end
      end
    end
  end

  // Present one op and hold it until accepted; the expected result enters the scoreboard at acceptance
  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o);
    int waited = 0;
    bus.in_valid = 1'b1; bus.A = a; bus.B = b; bus.op = o;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    n_checks++;
    if (!bus.in_ready) begin
      n_errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", bus.in_ready, waited);
    end else begin
      @(posedge clk);
      sb_q.push_back(model(a, b, o));
      n_pushed++;
    end
    #1 bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been consumed
  task automatic wait_drain(input string name);
    int t = 0;
    while (sb_q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.result, bus.mul_high, bus.SREG} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got ov=%b busy=%b res=%h hi=%h SREG=%b, expected all 0",
               bus.out_valid, bus.busy, bus.result, bus.mul_high, bus.SREG);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1 and 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_spec_vectors();
    logic [7:0] va[4]  = '{8'd6, 8'd127, 8'd5, 8'd1};
    logic [7:0] vb[4]  = '{8'd9, 8'd125, 8'd5, 8'd2};
    logic [3:0] vo[4]  = '{4'd0, 4'd0, 4'd1, 4'd7};
    logic [7:0] vr[4]  = '{8'd15, 8'd252, 8'd0, 8'd1};
    logic [3:0] vs[4]  = '{4'b0000, 4'b1100, 4'b0001, 4'b0110};
    int lat;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      send_op(va[i], vb[i], vo[i]);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 20);
      n_checks++;
      if (lat !== 1 || bus.result !== vr[i] || bus.SREG !== vs[i]) begin
        n_errors++;
        $display("FAIL spec_vec%0d: latency=%0d result=%0d SREG=%b, expected latency=1 result=%0d SREG=%b",
                 i, lat, bus.result, bus.SREG, vr[i], vs[i]);
      end
      @(posedge clk); #1;
    end
    wait_drain("spec");
  endtask

  task automatic test_mul();
    logic ok = 1'b1;
    @(posedge clk); #1;
    send_op(8'd13, 8'd85, 4'd2);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL mul_busy_c%0d: busy=%b in_ready=%b out_valid=%b, expected 1 0 0",
                 k, bus.busy, bus.in_ready, bus.out_valid);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.mul_high !== 8'h04 ||
        bus.result !== 8'h51 || bus.SREG !== 4'b1010) begin
      n_errors++;
      $display("FAIL mul_done: ov=%b busy=%b hi=%h res=%h SREG=%b, expected 1 0 04 51 1010",
               bus.out_valid, bus.busy, bus.mul_high, bus.result, bus.SREG);
    end
    wait_drain("mul");
  endtask

  task automatic test_all_ops();
    logic [7:0] pa[6] = '{8'h5A, 8'h80, 8'hFF, 8'h00, 8'h81, 8'h96};
    logic [7:0] pb[6] = '{8'h33, 8'h01, 8'hFF, 8'h00, 8'h0F, 8'h18};
    @(posedge clk); #1;
    for (int p = 0; p < 6; p++)
      for (int o = 0; o < 16; o++)
        send_op(pa[p], pb[p], 4'(o));
    for (int i = 0; i < 40; i++)
      send_op(8'($urandom_range(255)), 8'($urandom_range(255)), 4'($urandom_range(15)));
    wait_drain("all_ops");
  endtask

  task automatic test_backpressure();
    exp_t e1;
    int t;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send_op(8'd10, 8'd20, 4'd0);
    e1 = model(10, 20, 0);
    bus.in_valid = 1'b1; bus.A = 8'd200; bus.B = 8'd100; bus.op = 4'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== e1.res || bus.SREG !== e1.sreg) begin
        n_errors++;
        $display("FAIL stall_c%0d: in_ready=%b ov=%b res=%h SREG=%b, expected 0 1 %h %b",
                 k, bus.in_ready, bus.out_valid, bus.result, bus.SREG, e1.res, e1.sreg);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release: in_ready=%b, expected 1", bus.in_ready);
    end
    @(posedge clk);
    sb_q.push_back(model(200, 100, 1));
    n_pushed++;
    #1 bus.in_valid = 1'b0;
    wait_drain("stall");
    // Multiplier result held in DONE while the consumer stalls
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send_op(8'd200, 8'd3, 4'd2);
    e1 = model(200, 3, 2);
    t = 0;
    while (!bus.out_valid && t < 20) begin @(negedge clk); t++; end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== e1.res || bus.mul_high !== e1.hi) begin
        n_errors++;
        $display("FAIL mul_stall_c%0d: in_ready=%b ov=%b res=%h hi=%h, expected 0 1 %h %h",
                 k, bus.in_ready, bus.out_valid, bus.result, bus.mul_high, e1.res, e1.hi);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain("mul_stall");
  endtask

  task automatic test_back_to_back();
    int c0, p0;
    @(posedge clk); #1;
    c0 = cyc;
    p0 = n_pops;
    for (int i = 0; i < 6; i++)
      send_op(8'(i * 37 + 5), 8'(i * 11 + 1), 4'd0);
    n_checks++;
    if (cyc - c0 !== 6) begin
      n_errors++;
      $display("FAIL b2b_accept: 6 ops took %0d cycles, expected 6", cyc - c0);
    end
    @(negedge clk); #1;
    n_checks++;
    if (n_pops - p0 !== 6) begin
      n_errors++;
      $display("FAIL b2b_results: %0d results by next cycle, expected 6", n_pops - p0);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_during_mul();
    logic seen = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.A = 8'd255; bus.B = 8'd255; bus.op = 4'd2;
    @(negedge clk);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.result, bus.mul_high, bus.SREG} !== 21'd0) begin
      n_errors++;
      $display("FAIL mul_abort_clear: ov=%b busy=%b res=%h hi=%h SREG=%b, expected all 0",
               bus.out_valid, bus.busy, bus.result, bus.mul_high, bus.SREG);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL mul_abort_quiet: out_valid or busy seen as 1 after reset, expected 0");
    end
    @(posedge clk); #1;
    send_op(8'd1, 8'd1, 4'd0);
    wait_drain("post_reset");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.A         = 8'd0;
    bus.B         = 8'd0;
    bus.op        = 4'd0;
    bus.out_ready = 1'b1;
    test_reset();
    test_spec_vectors();
    test_mul();
    test_all_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_during_mul();
    n_checks++;
    if (n_pops !== n_pushed) begin
      n_errors++;
      $display("FAIL op_count: %0d results consumed, expected %0d", n_pops, n_pushed);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
